mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_if.sv | 46 ++++
 rtl/mem_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Request/response bundle between the pipeline (IF and MEM stages), the
// memory controller and its byte-wide RAM port. Signal names match the
// controller's documented port list.
interface mem_ctrl_if;
  // instruction-fetch side
  logic        if_enable_in;
  logic [31:0] if_addr_in;
  logic        flush_in;
  logic [31:0] inst_out;
  logic        inst_done_out;
  logic        busy_if_out;
  // load/store side
  logic        mem_enable_in;
  logic        mem_wr_in;
  logic [31:0] mem_addr_in;
  logic [1:0]  mem_len_in;
  logic [31:0] mem_wdata_in;
  logic [31:0] mem_rdata_out;
  logic        mem_done_out;
  logic        busy_mem_out;
  // byte-wide RAM port
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  // The controller's view.
  modport slave (
    input  if_enable_in, if_addr_in, flush_in,
    input  mem_enable_in, mem_wr_in, mem_addr_in, mem_len_in, mem_wdata_in,
    input  ram_din,
    output inst_out, inst_done_out, busy_if_out,
    output mem_rdata_out, mem_done_out, busy_mem_out,
    output ram_dout, ram_a, ram_wr
  );

  // The pipeline/RAM environment's view.
  modport master (
    output if_enable_in, if_addr_in, flush_in,
    output mem_enable_in, mem_wr_in, mem_addr_in, mem_len_in, mem_wdata_in,
    output ram_din,
    input  inst_out, inst_done_out, busy_if_out,
    input  mem_rdata_out, mem_done_out, busy_mem_out,
    input  ram_dout, ram_a, ram_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetches and
// load/stores onto a byte-wide RAM with 1-cycle read latency. Loads/fetches
// of N bytes complete N+1 cycles after acceptance, stores likewise; every
// output is a flop.
module mem_ctrl (
  input  logic      clk,
  input  logic      rst,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_RD  = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;        // next byte index; reads land in lane cnt-1
  logic [2:0]      nbytes_q, nbytes_d;  // transfer size in bytes (1, 2 or 4)
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0][7:0] buf_q, buf_d;        // read assembly buffer, lane 0 = lowest byte

  logic [31:0]     ram_a_q, ram_a_d;
  logic [7:0]      ram_dout_q, ram_dout_d;
  logic            ram_wr_q, ram_wr_d;
  logic [31:0]     inst_q, inst_d;
  logic            inst_done_q, inst_done_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            mem_done_q, mem_done_d;
  logic            busy_if_q, busy_if_d;
  logic            busy_mem_q, busy_mem_d;

  logic [1:0]      rd_lane;
  logic [31:0]     next_addr;

  // cnt runs 1..4 while busy; the 2-bit subtraction maps 4 back onto lane 3.
  assign rd_lane   = cnt_q[1:0] - 2'd1;
  assign next_addr = addr_q + {29'd0, cnt_q};

  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    case (len)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Next-state, datapath and next-output logic.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    nbytes_d    = nbytes_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = 1'b0;
    inst_d      = inst_q;
    inst_done_d = 1'b0;
    rdata_d     = rdata_q;
    mem_done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // MEM has priority; a requester that just got its done pulse is not
        // re-accepted in that same cycle.
        if (bus.mem_enable_in && !mem_done_q) begin
          addr_d   = bus.mem_addr_in;
          nbytes_d = len_to_bytes(bus.mem_len_in);
          wdata_d  = bus.mem_wdata_in;
          buf_d    = '0;
          cnt_d    = 3'd1;
          ram_a_d  = bus.mem_addr_in;
          if (bus.mem_wr_in) begin
            state_d    = MEM_WR;
            ram_wr_d   = 1'b1;
            ram_dout_d = bus.mem_wdata_in[7:0];
          end else begin
            state_d = MEM_RD;
          end
        end else if (bus.if_enable_in && !bus.flush_in && !inst_done_q) begin
          addr_d   = bus.if_addr_in;
          nbytes_d = 3'd4;
          buf_d    = '0;
          cnt_d    = 3'd1;
          ram_a_d  = bus.if_addr_in;
          state_d  = IF_RD;
        end
      end

      IF_RD, MEM_RD: begin
        if (state_q == IF_RD && bus.flush_in) begin
          // Taken branch: drop the fetch silently.
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          buf_d[rd_lane] = bus.ram_din;
          if (cnt_q == nbytes_q) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            if (state_q == IF_RD) begin
              inst_d      = buf_d;
              inst_done_d = 1'b1;
            end else begin
              rdata_d    = buf_d;
              mem_done_d = 1'b1;
            end
          end else begin
            ram_a_d = next_addr;
            cnt_d   = cnt_q + 3'd1;
          end
        end
      end

      MEM_WR: begin
        if (cnt_q == nbytes_q) begin
          state_d    = IDLE;
          cnt_d      = 3'd0;
          mem_done_d = 1'b1;
        end else begin
          ram_wr_d   = 1'b1;
          ram_a_d    = next_addr;
          ram_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          cnt_d      = cnt_q + 3'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_if_d  = (state_d == IF_RD);
    busy_mem_d = (state_d == MEM_RD) || (state_d == MEM_WR);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      nbytes_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      inst_q      <= '0;
      inst_done_q <= 1'b0;
      rdata_q     <= '0;
      mem_done_q  <= 1'b0;
      busy_if_q   <= 1'b0;
      busy_mem_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nbytes_q    <= nbytes_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      inst_q      <= inst_d;
      inst_done_q <= inst_done_d;
      rdata_q     <= rdata_d;
      mem_done_q  <= mem_done_d;
      busy_if_q   <= busy_if_d;
      busy_mem_q  <= busy_mem_d;
    end
  end

  assign bus.ram_a         = ram_a_q;
  assign bus.ram_dout      = ram_dout_q;
  assign bus.ram_wr        = ram_wr_q;
  assign bus.inst_out      = inst_q;
  assign bus.inst_done_out = inst_done_q;
  assign bus.busy_if_out   = busy_if_q;
  assign bus.mem_rdata_out = rdata_q;
  assign bus.mem_done_out  = mem_done_q;
  assign bus.busy_mem_out  = busy_mem_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: byte RAM model, expected-response queues filled by
// the stimulus and drained by an independent monitor, directed scenarios and
// a randomized sequence of fetches, loads and stores.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst;

  mem_ctrl_if bus ();

  mem_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- RAM model: 64 KiB, indexed by the low 16 address bits
  logic [7:0] ram [0:65535];
  logic       ram_ready = 1'b0;

  function automatic logic [7:0] init_byte(input int a);
    return 8'((a * 37) ^ (a >> 8) ^ 8'h5a);
  endfunction

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 65536; i++) ram[i] <= init_byte(i);
      ram_ready <= 1'b1;
    end else if (bus.ram_wr) begin
      ram[bus.ram_a[15:0]] <= bus.ram_dout;
    end
  end

  assign bus.ram_din = ram[bus.ram_a[15:0]];

  // ---------------- reference model helpers
  function automatic logic [31:0] model_read(input logic [31:0] addr, input int n);
    logic [31:0] v;
    logic [31:0] a;
    v = '0;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      v = v | (32'(ram[a[15:0]]) << (8 * i));
    end
    return v;
  endfunction

  function automatic int len_bytes(input logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  // ---------------- scoreboard
  typedef struct packed { logic [31:0] a; logic [7:0] d; } wr_t;
  typedef struct packed { logic is_store; logic [31:0] data; } mem_exp_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_inst[$];
  mem_exp_t    exp_mem[$];
  logic [31:0] last_inst, last_rdata;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string act, input string req);
    checks++;
    errors++;
    $display("FAIL %s: actual=%s required=%s (t=%0t)", name, act, req, $time);
  endtask

  // Monitor: compares every DUT response against the queued expectations.
  always @(negedge clk) begin
    logic [31:0] e;
    mem_exp_t    m;
    wr_t         w;
    if (bus.ram_wr === 1'b1) begin
      if (exp_wr.size() == 0) fail_now("ram_wr", "write strobe", "no write");
      else begin
        w = exp_wr.pop_front();
        check("wr_addr", bus.ram_a, w.a);
        check("wr_data", 32'(bus.ram_dout), 32'(w.d));
        check("wr_busy_mem", 32'(bus.busy_mem_out), 32'd1);
      end
    end
    if (rst) begin
      last_inst  = '0;
      last_rdata = '0;
    end else begin
      check("busy_exclusive", 32'(bus.busy_if_out & bus.busy_mem_out), 32'd0);
      if (bus.inst_done_out) begin
        if (exp_inst.size() == 0) fail_now("inst_done", "pulse", "no pulse");
        else begin
          e = exp_inst.pop_front();
          last_inst = e;
          check("inst_out", bus.inst_out, e);
        end
        check("busy_if_in_done", 32'(bus.busy_if_out), 32'd0);
      end else begin
        check("inst_hold", bus.inst_out, last_inst);
      end
      if (bus.mem_done_out) begin
        if (exp_mem.size() == 0) fail_now("mem_done", "pulse", "no pulse");
        else begin
          m = exp_mem.pop_front();
          if (m.is_store) check("store_rdata_hold", bus.mem_rdata_out, last_rdata);
          else begin
            check("mem_rdata", bus.mem_rdata_out, m.data);
            last_rdata = m.data;
          end
        end
        check("busy_mem_in_done", 32'(bus.busy_mem_out), 32'd0);
      end else begin
        check("rdata_hold", bus.mem_rdata_out, last_rdata);
      end
    end
  end

  // ---------------- stimulus helpers (all entered/left at posedge+1)

  // After acceptance the requester's side fields are scrambled to show they
  // were latched; the enable itself is held until done.
  task automatic scramble(input logic is_if);
    if (is_if) bus.if_addr_in = $urandom;
    else begin
      bus.mem_addr_in  = $urandom;
      bus.mem_wdata_in = $urandom;
      bus.mem_len_in   = 2'($urandom_range(0, 3));
      bus.mem_wr_in    = 1'($urandom_range(0, 1));
    end
  endtask

  // Waits for the done pulse; checks latency N+1, N busy cycles and the
  // address sequence addr, addr+1, ... seen on the RAM port while busy.
  task automatic wait_done(input logic is_if, input int n, input logic [31:0] addr);
    int          cycles;
    int          busy;
    logic        done;
    logic [31:0] trace[$];
    cycles = 0;
    busy   = 0;
    done   = 1'b0;
    while (!done && cycles < 40) begin
      @(posedge clk);
      cycles++;
      if (cycles == 1) begin
        #1;
        scramble(is_if);
      end
      @(negedge clk);
      done = is_if ? bus.inst_done_out : bus.mem_done_out;
      if (!done && (is_if ? bus.busy_if_out : bus.busy_mem_out)) begin
        busy++;
        trace.push_back(bus.ram_a);
      end
    end
    if (!done) fail_now(is_if ? "if_timeout" : "mem_timeout", "no done", "done pulse");
    else begin
      check(is_if ? "if_latency" : "mem_latency", 32'(cycles), 32'(n + 1));
      check(is_if ? "if_busy_cycles" : "mem_busy_cycles", 32'(busy), 32'(n));
      for (int i = 0; i < trace.size() && i < n; i++)
        check("ram_addr_seq", trace[i], addr + 32'(i));
    end
  endtask

  task automatic do_if(input logic [31:0] addr);
    exp_inst.push_back(model_read(addr, 4));
    bus.if_enable_in = 1'b1;
    bus.if_addr_in   = addr;
    wait_done(1'b1, 4, addr);
    @(posedge clk);
    #1;
    bus.if_enable_in = 1'b0;
  endtask

  task automatic do_mem(input logic wr, input logic [31:0] addr, input logic [1:0] len,
                        input logic [31:0] wdata, input logic fl);
    int       n;
    mem_exp_t e;
    wr_t      w;
    n = len_bytes(len);
    e.is_store = wr;
    e.data     = wr ? 32'd0 : model_read(addr, n);
    if (wr) begin
      for (int i = 0; i < n; i++) begin
        w.a = addr + 32'(i);
        w.d = 8'(wdata >> (8 * i));
        exp_wr.push_back(w);
      end
    end
    exp_mem.push_back(e);
    bus.mem_enable_in = 1'b1;
    bus.mem_wr_in     = wr;
    bus.mem_addr_in   = addr;
    bus.mem_len_in    = len;
    bus.mem_wdata_in  = wdata;
    bus.flush_in      = fl;
    wait_done(1'b0, n, addr);
    @(posedge clk);
    #1;
    bus.mem_enable_in = 1'b0;
    bus.flush_in      = 1'b0;
    if (wr) check("store_write_count", 32'(exp_wr.size()), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ram_a"}, bus.ram_a, 32'd0);
    check({tag, "_ram_dout"}, 32'(bus.ram_dout), 32'd0);
    check({tag, "_ram_wr"}, 32'(bus.ram_wr), 32'd0);
    check({tag, "_inst_out"}, bus.inst_out, 32'd0);
    check({tag, "_inst_done"}, 32'(bus.inst_done_out), 32'd0);
    check({tag, "_busy_if"}, 32'(bus.busy_if_out), 32'd0);
    check({tag, "_rdata"}, bus.mem_rdata_out, 32'd0);
    check({tag, "_mem_done"}, 32'(bus.mem_done_out), 32'd0);
    check({tag, "_busy_mem"}, 32'(bus.busy_mem_out), 32'd0);
  endtask

  // Hard stop if something wedges the stimulus itself.
  initial begin
    #500000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence
  initial begin
    int          c;
    logic        done;
    logic [31:0] a;
    int          kind;
    int          sel;

    rst               = 1'b1;
    bus.if_enable_in  = 1'b0;
    bus.if_addr_in    = '0;
    bus.flush_in      = 1'b0;
    bus.mem_enable_in = 1'b0;
    bus.mem_wr_in     = 1'b0;
    bus.mem_addr_in   = '0;
    bus.mem_len_in    = '0;
    bus.mem_wdata_in  = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Seed 0x100 with addi a0,x0,0 (0x00000513) through the store path,
    // then fetch it.
    do_mem(1'b1, 32'h100, 2'd2, 32'h0000_0513, 1'b0);
    check("seed_0x100", model_read(32'h100, 4), 32'h0000_0513);
    do_if(32'h100);

    // Simultaneous IF and 1-byte load: MEM first, IF accepted on the edge
    // that ends the mem_done cycle.
    exp_mem.push_back('{is_store: 1'b0, data: model_read(32'h1004, 1)});
    exp_inst.push_back(model_read(32'h0, 4));
    bus.if_enable_in  = 1'b1;
    bus.if_addr_in    = 32'h0;
    bus.mem_enable_in = 1'b1;
    bus.mem_wr_in     = 1'b0;
    bus.mem_addr_in   = 32'h1004;
    bus.mem_len_in    = 2'd0;
    wait_done(1'b0, 1, 32'h1004);
    c    = 0;
    done = 1'b0;
    while (!done && c < 40) begin
      @(posedge clk);
      c++;
      if (c == 1) begin
        #1;
        bus.mem_enable_in = 1'b0;
      end
      @(negedge clk);
      done = bus.inst_done_out;
    end
    check("if_after_mem_latency", 32'(c), 32'd5);
    @(posedge clk);
    #1;
    bus.if_enable_in = 1'b0;

    // 2-byte store: exactly two writes, upper bytes of the word untouched.
    do_mem(1'b1, 32'h2000, 2'd1, 32'hAABB_CCDD, 1'b0);
    check("st2_byte0", 32'(ram[16'h2000]), 32'h0000_00DD);
    check("st2_byte1", 32'(ram[16'h2001]), 32'h0000_00CC);
    check("st2_byte2", 32'(ram[16'h2002]), 32'(init_byte(32'h2002)));

    // Flush while the second fetch byte is in flight.
    bus.if_enable_in = 1'b1;
    bus.if_addr_in   = 32'h3100;
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.flush_in     = 1'b1;
    bus.if_enable_in = 1'b0;
    @(posedge clk);
    #1;
    bus.flush_in = 1'b0;
    @(negedge clk);
    check("flush_to_idle", 32'(bus.busy_if_out), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    do_if(32'h3200);

    // Flush in IDLE holds off IF acceptance for that cycle only.
    exp_inst.push_back(model_read(32'h3300, 4));
    bus.if_enable_in = 1'b1;
    bus.if_addr_in   = 32'h3300;
    bus.flush_in     = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_in = 1'b0;
    @(negedge clk);
    check("flush_blocks_accept", 32'(bus.busy_if_out), 32'd0);
    wait_done(1'b1, 4, 32'h3300);
    @(posedge clk);
    #1;
    bus.if_enable_in = 1'b0;

    // 4-byte load across the top of the address space, flush held high.
    do_mem(1'b0, 32'hFFFF_FFFE, 2'd2, 32'h0, 1'b1);
    do_mem(1'b0, 32'h2000, 2'd3, 32'h0, 1'b0);

    // Reset in the middle of a 4-byte store.
    exp_wr.push_back('{a: 32'h2100, d: 8'h44});
    exp_wr.push_back('{a: 32'h2101, d: 8'h33});
    exp_wr.push_back('{a: 32'h2102, d: 8'h22});
    exp_wr.push_back('{a: 32'h2103, d: 8'h11});
    bus.mem_enable_in = 1'b1;
    bus.mem_wr_in     = 1'b1;
    bus.mem_addr_in   = 32'h2100;
    bus.mem_len_in    = 2'd2;
    bus.mem_wdata_in  = 32'h1122_3344;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst               = 1'b1;
    bus.mem_enable_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_outputs_zero("midrst");
    check("midrst_writes_left", 32'(exp_wr.size()), 32'd2);
    exp_wr.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_mem(1'b0, 32'h2100, 2'd2, 32'h0, 1'b0);

    // Randomized mix.
    for (int k = 0; k < 60; k++) begin
      kind = $urandom_range(0, 2);
      sel  = $urandom_range(0, 3);
      if (sel == 0)      a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      else if (sel == 1) a = $urandom;
      else               a = 32'h3000 + 32'($urandom_range(0, 255));
      case (kind)
        0:       do_if(a);
        1:       do_mem(1'b0, a, 2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)));
        default: do_mem(1'b1, a, 2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)));
      endcase
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("inst_queue_empty", 32'(exp_inst.size()), 32'd0);
    check("mem_queue_empty", 32'(exp_mem.size()), 32'd0);
    check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
